// File: rtl/shift_arbiter.sv
// Two-requester round-robin shift unit: grants one request, shifts it in passes
// of at most 7 positions through a single shifter, then holds the result until taken.
//
// state | meaning
// IDLE  | waiting for a request; grant and capture happen here
// SHIFT | applying up to 7 positions per cycle until remaining is 0
// DONE  | result presented on rsp_*; held until rsp_ready

module shifter (
   input  logic [7:0] operand,
   input  logic       direction,
   input  logic [2:0] shift,
   output logic [7:0] result
);
   assign result = direction ? (operand << shift) : (operand >> shift);
endmodule

module shift_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_operand,
   input  logic       req0_direction,
   input  logic [3:0] req0_amount,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_operand,
   input  logic       req1_direction,
   input  logic [3:0] req1_amount,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_id
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] work_q, work_d;
   logic [3:0] remaining_q, remaining_d;
   logic       dir_q, dir_d;
   logic       id_q, id_d;
   logic       grant_id;
   logic [2:0] shift_amt;
   logic [7:0] shift_result;

   shifter u_shifter (
      .operand   (work_q),
      .direction (dir_q),
      .shift     (shift_amt),
      .result    (shift_result)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      work_d       = work_q;
      remaining_d  = remaining_q;
      dir_d        = dir_q;
      id_d         = id_q;
      grant_id     = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      shift_amt    = (remaining_q > 4'd7) ? 3'd7 : remaining_q[2:0];
      case (state_q)
         IDLE: begin
            // reset gating keeps readies low while the async reset is held
            if (!reset && (req0_valid || req1_valid)) begin
               grant_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
               req0_ready   = ~grant_id;
               req1_ready   = grant_id;
               last_grant_d = grant_id;
               id_d         = grant_id;
               work_d       = grant_id ? req1_operand   : req0_operand;
               dir_d        = grant_id ? req1_direction : req0_direction;
               remaining_d  = grant_id ? req1_amount    : req0_amount;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            work_d      = shift_result;
            remaining_d = remaining_q - {1'b0, shift_amt};
            if (remaining_d == 4'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         work_q       <= 8'h00;
         remaining_q  <= 4'd0;
         dir_q        <= 1'b0;
         id_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         work_q       <= work_d;
         remaining_q  <= remaining_d;
         dir_q        <= dir_d;
         id_q         <= id_d;
      end
   end

   assign rsp_valid  = (state_q == DONE);
   assign rsp_result = work_q;
   assign rsp_id     = id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a vector table of single requests plus
// hand-written sequences for arbitration, response back-pressure and mid-flight reset.

module tb_shift_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_ready, req0_direction;
   logic [7:0] req0_operand;
   logic [3:0] req0_amount;
   logic       req1_valid, req1_ready, req1_direction;
   logic [7:0] req1_operand;
   logic [3:0] req1_amount;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [7:0] rsp_result;

   int pass_cnt  = 0;
   int total_cnt = 0;

   shift_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_ready     (req0_ready),
      .req0_operand   (req0_operand),
      .req0_direction (req0_direction),
      .req0_amount    (req0_amount),
      .req1_valid     (req1_valid),
      .req1_ready     (req1_ready),
      .req1_operand   (req1_operand),
      .req1_direction (req1_direction),
      .req1_amount    (req1_amount),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_result     (rsp_result),
      .rsp_id         (rsp_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       id;
      logic [7:0] operand;
      logic       dir;
      logic [3:0] amount;
      logic [7:0] exp_result;
      int         exp_lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input logic id, input logic [7:0] op, input logic dir,
                          input logic [3:0] amt);
      if (id) begin
         req1_valid = 1'b1; req1_operand = op; req1_direction = dir; req1_amount = amt;
      end else begin
         req0_valid = 1'b1; req0_operand = op; req0_direction = dir; req0_amount = amt;
      end
   endtask

   task automatic scramble();
      req0_operand = 8'h5A; req0_direction = ~req0_direction; req0_amount = 4'hF;
      req1_operand = 8'hA5; req1_direction = ~req1_direction; req1_amount = 4'hF;
   endtask

   // called one cycle after acceptance; lat counts edges since the accept edge
   task automatic wait_rsp(inout int lat);
      while (!rsp_valid && lat < 12) begin
         tick();
         lat++;
      end
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
   endtask

   initial begin
      int  lat;
      logic seen;

      vecs[0]  = '{1'b0, 8'hC3, 1'b0, 4'd1,  8'h61, 2};
      vecs[1]  = '{1'b1, 8'h80, 1'b0, 4'd7,  8'h01, 2};
      vecs[2]  = '{1'b1, 8'h01, 1'b1, 4'd15, 8'h00, 4};
      vecs[3]  = '{1'b0, 8'hAA, 1'b1, 4'd0,  8'hAA, 2};
      vecs[4]  = '{1'b0, 8'hB5, 1'b1, 4'd3,  8'hA8, 2};
      vecs[5]  = '{1'b1, 8'hF0, 1'b0, 4'd9,  8'h00, 3};
      vecs[6]  = '{1'b0, 8'h81, 1'b0, 4'd7,  8'h01, 2};
      vecs[7]  = '{1'b1, 8'h0F, 1'b1, 4'd4,  8'hF0, 2};
      vecs[8]  = '{1'b0, 8'hFF, 1'b0, 4'd8,  8'h00, 3};
      vecs[9]  = '{1'b1, 8'h3C, 1'b0, 4'd2,  8'h0F, 2};
      vecs[10] = '{1'b0, 8'h01, 1'b1, 4'd7,  8'h80, 2};
      vecs[11] = '{1'b1, 8'hFF, 1'b1, 4'd14, 8'h00, 3};

      // reset held with both requesters asking
      reset = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_operand = 8'h12; req0_direction = 1'b0; req0_amount = 4'd1;
      req1_valid = 1'b1; req1_operand = 8'h34; req1_direction = 1'b1; req1_amount = 4'd1;
      tick();
      tick();
      chk("rst_readies", {req1_ready, req0_ready}, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_result", rsp_result, 8'h00);
      chk("rst_rsp_id", rsp_id, 1'b0);

      // tie after reset: req0 first, then req1, then back to req0
      reset = 1'b0;
      #1;
      chk("tie1_grant", {req1_ready, req0_ready}, 2'b01);
      tick();
      chk("tie1_shift_readies", {req1_ready, req0_ready}, 2'b00);
      lat = 1;
      wait_rsp(lat);
      chk("tie1_lat", lat, 2);
      chk("tie1_result", rsp_result, 8'h09);
      chk("tie1_id", rsp_id, 1'b0);
      rsp_ready = 1'b1;
      #1;
      chk("tie1_done_hs_readies", {req1_ready, req0_ready}, 2'b00);
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("tie2_grant", {req1_ready, req0_ready}, 2'b10);
      tick();
      lat = 1;
      wait_rsp(lat);
      chk("tie2_lat", lat, 2);
      chk("tie2_result", rsp_result, 8'h68);
      chk("tie2_id", rsp_id, 1'b1);
      // back-pressure: result must hold and no grant while DONE waits
      for (int c = 0; c < 3; c++) begin
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_result", rsp_result, 8'h68);
         chk("hold_id", rsp_id, 1'b1);
         chk("hold_readies", {req1_ready, req0_ready}, 2'b00);
         tick();
      end
      handshake();
      chk("tie3_grant", {req1_ready, req0_ready}, 2'b01);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat = 1;
      wait_rsp(lat);
      chk("tie3_result", rsp_result, 8'h09);
      handshake();

      // vector table, one requester at a time; inputs scrambled after accept
      for (int i = 0; i < 12; i++) begin
         set_req(vecs[i].id, vecs[i].operand, vecs[i].dir, vecs[i].amount);
         #1;
         chk($sformatf("v%0d_grant", i), {req1_ready, req0_ready},
             vecs[i].id ? 2'b10 : 2'b01);
         tick();
         req0_valid = 1'b0; req1_valid = 1'b0;
         scramble();
         lat = 1;
         wait_rsp(lat);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_result", i), rsp_result, vecs[i].exp_result);
         chk($sformatf("v%0d_id", i), rsp_id, vecs[i].id);
         handshake();
         chk($sformatf("v%0d_post_valid", i), rsp_valid, 1'b0);
      end

      // reset during the second SHIFT pass of an amount-10 request
      set_req(1'b1, 8'hFF, 1'b0, 4'd10);
      #1;
      chk("rst_mid_grant", {req1_ready, req0_ready}, 2'b10);
      tick();
      req1_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", rsp_valid, 1'b0);
      chk("rst_mid_result", rsp_result, 8'h00);
      chk("rst_mid_id", rsp_id, 1'b0);
      tick();
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("rst_mid_no_rsp", seen, 1'b0);
      set_req(1'b0, 8'hAA, 1'b0, 4'd4);
      set_req(1'b1, 8'h11, 1'b1, 4'd1);
      #1;
      chk("rst_mid_idle_tie", {req1_ready, req0_ready}, 2'b01);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      lat = 1;
      wait_rsp(lat);
      chk("rst_mid_after_result", rsp_result, 8'h0A);
      chk("rst_mid_after_id", rsp_id, 1'b0);
      handshake();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
